// File: rtl/reg_writeback.sv
// Write-back arbiter for the integer register file: merges never-stalled ALU
// results with buffered, formatted load responses and answers hazard queries.
module reg_writeback #(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [n-1:0]               alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [n-1:0]               ld_data,
  input  logic [1:0]                 ld_size,
  input  logic                       ld_unsigned,
  input  logic [4:0]                 q_rs1,
  input  logic [4:0]                 q_rs2,
  output logic                       hit1,
  output logic                       hit2,
  output logic                       regw,
  output logic [4:0]                 waddr,
  output logic [n-1:0]               wdata,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int CW = $clog2(DEPTH+1);

  // Buffer is kept compacted: slots [0, cnt) hold live entries, slot 0 is the head.
  logic [4:0]    ent_rd   [DEPTH];
  logic [n-1:0]  ent_data [DEPTH];
  logic [CW-1:0] cnt;

  logic [4:0]    nxt_rd   [DEPTH];
  logic [n-1:0]  nxt_data [DEPTH];
  logic [CW-1:0] nxt_cnt;
  logic [DEPTH-1:0] keep;
  int            rank [DEPTH];
  int            kept;

  logic          alu_win;
  logic          head_valid;
  logic          pop;
  logic          accept;
  logic          bypass;
  logic          push;
  logic [n-1:0]  ld_fmt;
  logic          sgn_b;
  logic          sgn_h;

  assign sgn_b = ~ld_unsigned & ld_data[7];
  assign sgn_h = ~ld_unsigned & ld_data[15];

  always_comb begin
    case (ld_size)
      2'b00:   ld_fmt = {{(n-8){sgn_b}}, ld_data[7:0]};
      2'b01:   ld_fmt = {{(n-16){sgn_h}}, ld_data[15:0]};
      default: ld_fmt = ld_data;
    endcase
  end

  always_comb begin
    alu_win    = alu_valid && (alu_rd != 5'd0);
    head_valid = (cnt != '0);
    pop        = !alu_win && head_valid;
    ld_ready   = (cnt < CW'(DEPTH)) || pop;
    accept     = ld_valid && ld_ready;
    bypass     = !alu_win && !head_valid && accept && (ld_rd != 5'd0);
    // A same-cycle load to the ALU's destination is stale on arrival.
    push       = accept && (ld_rd != 5'd0) && !bypass &&
                 !(alu_win && (ld_rd == alu_rd));
  end

  always_comb begin
    kept     = 0;
    nxt_rd   = ent_rd;
    nxt_data = ent_data;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = (CW'(i) < cnt) && !(pop && (i == 0)) &&
                !(alu_win && (ent_rd[i] == alu_rd));
      rank[i] = kept;
      if (keep[i]) kept = kept + 1;
    end
    for (int j = 0; j < DEPTH; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (rank[i] == j)) begin
          nxt_rd[j]   = ent_rd[i];
          nxt_data[j] = ent_data[i];
        end
      end
      if (push && (kept == j)) begin
        nxt_rd[j]   = ld_rd;
        nxt_data[j] = ld_fmt;
      end
    end
    nxt_cnt = CW'(kept) + CW'(push);
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt) && (ent_rd[i] == q_rs1) && (q_rs1 != 5'd0)) hit1 = 1'b1;
      if ((CW'(i) < cnt) && (ent_rd[i] == q_rs2) && (q_rs2 != 5'd0)) hit2 = 1'b1;
    end
  end

  assign pending = cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regw  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      cnt <= nxt_cnt;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= nxt_rd[i];
        ent_data[i] <= nxt_data[i];
      end
      regw <= alu_win || pop || bypass;
      if (alu_win) begin
        waddr <= alu_rd;
        wdata <= alu_data;
      end else if (pop) begin
        waddr <= ent_rd[0];
        wdata <= ent_data[0];
      end else if (bypass) begin
        waddr <= ld_rd;
        wdata <= ld_fmt;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, reset corner case, and
// random traffic checked against a queue-based reference model.
module tb_reg_writeback;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [1:0]  ld_size = '0;
  logic        ld_unsigned = 1'b0;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        hit1, hit2, regw;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  pending;

  reg_writeback #(.n(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hit1(hit1), .hit2(hit2),
    .regw(regw), .waddr(waddr), .wdata(wdata), .pending(pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic [1:0]  lsz;
    logic        lu;
    logic [4:0]  q;
    logic        e_ready;
    logic        e_hit;
    logic        e_regw;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_pend;
  } vec_t;

  ent_t        mq[$];
  logic        m_regw = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  vec_t        tv[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz, input logic u);
    int unsigned b, h;
    b = d & 32'h0000_00FF;
    h = d & 32'h0000_FFFF;
    case (sz)
      2'd0:    return (u || b < 128)   ? b : b - 256;
      2'd1:    return (u || h < 32768) ? h : h - 65536;
      default: return d;
    endcase
  endfunction

  function automatic logic model_ready();
    logic aw;
    aw = alu_valid && (alu_rd != 0);
    return (mq.size() < DEPTH) || (!aw && mq.size() != 0);
  endfunction

  function automatic logic model_hit(input logic [4:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // Called with inputs settled before the rising edge; returns at the next falling edge.
  task automatic tick();
    logic        r, aw, acc;
    logic [31:0] f;
    ent_t        nq[$];
    ent_t        e;
    logic        nregw;
    logic [4:0]  nwaddr;
    logic [31:0] nwdata;
    r = model_ready();
    chk("ld_ready", 32'(ld_ready), 32'(r));
    chk("hit1", 32'(hit1), 32'(model_hit(q_rs1)));
    chk("hit2", 32'(hit2), 32'(model_hit(q_rs2)));
    aw  = alu_valid && (alu_rd != 0);
    acc = ld_valid && r;
    f   = fmt(ld_data, ld_size, ld_unsigned);
    e.rd = ld_rd;
    e.data = f;
    nq = {};
    nregw = 1'b0;
    nwaddr = m_waddr;
    nwdata = m_wdata;
    if (aw) begin
      nregw = 1'b1; nwaddr = alu_rd; nwdata = alu_data;
      foreach (mq[i]) if (mq[i].rd != alu_rd) nq.push_back(mq[i]);
      if (acc && ld_rd != 0 && ld_rd != alu_rd) nq.push_back(e);
    end else if (mq.size() > 0) begin
      nregw = 1'b1; nwaddr = mq[0].rd; nwdata = mq[0].data;
      nq = mq;
      void'(nq.pop_front());
      if (acc && ld_rd != 0) nq.push_back(e);
    end else if (acc && ld_rd != 0) begin
      nregw = 1'b1; nwaddr = ld_rd; nwdata = f;
    end
    @(posedge clock);
    #1;
    mq = nq;
    m_regw = nregw; m_waddr = nwaddr; m_wdata = nwdata;
    chk("regw", 32'(regw), 32'(m_regw));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("pending", 32'(pending), 32'(mq.size()));
    @(negedge clock);
  endtask

  function automatic void add(
    input logic av, input logic [4:0] ard, input logic [31:0] adata,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
    input logic [1:0] lsz, input logic lu, input logic [4:0] q,
    input logic er, input logic eh, input logic ew,
    input logic [4:0] ea, input logic [31:0] ed, input logic [1:0] ep);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata; v.lv = lv; v.lrd = lrd;
    v.ldata = ldata; v.lsz = lsz; v.lu = lu; v.q = q;
    v.e_ready = er; v.e_hit = eh; v.e_regw = ew;
    v.e_waddr = ea; v.e_wdata = ed; v.e_pend = ep;
    tv.push_back(v);
  endfunction

  task automatic set_idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; ld_size = '0; ld_unsigned = 1'b0;
    q_rs1 = '0; q_rs2 = '0;
  endtask

  initial begin
    // av ard adata | lv lrd ldata size uns | q | ready hit | regw waddr wdata pending
    add(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        2'd0, 0, 0,  1, 0, 1, 5,  32'hDEADBEEF, 0);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 0,  1, 0, 0, 5,  32'hDEADBEEF, 0);
    add(0, 0,  32'h0,        1, 3,  32'h000000F0, 2'd0, 0, 0,  1, 0, 1, 3,  32'hFFFFFFF0, 0);
    add(0, 0,  32'h0,        1, 3,  32'h000000F0, 2'd0, 1, 0,  1, 0, 1, 3,  32'h000000F0, 0);
    add(0, 0,  32'h0,        1, 3,  32'h00018000, 2'd1, 0, 0,  1, 0, 1, 3,  32'hFFFF8000, 0);
    add(0, 0,  32'h0,        1, 4,  32'h00018000, 2'd1, 1, 0,  1, 0, 1, 4,  32'h00008000, 0);
    add(0, 0,  32'h0,        1, 6,  32'h12345678, 2'd3, 0, 0,  1, 0, 1, 6,  32'h12345678, 0);
    add(1, 1,  32'h100,      1, 7,  32'h77,       2'd2, 0, 7,  1, 0, 1, 1,  32'h100,      1);
    add(1, 2,  32'h200,      1, 8,  32'h88,       2'd2, 0, 7,  1, 1, 1, 2,  32'h200,      2);
    add(1, 1,  32'h101,      1, 9,  32'h99,       2'd2, 0, 7,  0, 1, 1, 1,  32'h101,      2);
    add(1, 2,  32'h201,      1, 9,  32'h99,       2'd2, 0, 8,  0, 1, 1, 2,  32'h201,      2);
    add(0, 0,  32'h0,        1, 9,  32'h99,       2'd2, 0, 9,  1, 0, 1, 7,  32'h77,       2);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 9,  1, 1, 1, 8,  32'h88,       1);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 9,  1, 1, 1, 9,  32'h99,       0);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 0,  1, 0, 0, 9,  32'h99,       0);
    add(1, 11, 32'h5,        1, 10, 32'hAA,       2'd2, 0, 0,  1, 0, 1, 11, 32'h5,        1);
    add(1, 10, 32'h11,       0, 0,  32'h0,        2'd0, 0, 10, 1, 1, 1, 10, 32'h11,       0);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 10, 1, 0, 0, 10, 32'h11,       0);
    add(1, 0,  32'h33,       1, 0,  32'h44,       2'd2, 0, 0,  1, 0, 0, 10, 32'h11,       0);
    add(1, 12, 32'h1,        1, 13, 32'hD,        2'd2, 0, 0,  1, 0, 1, 12, 32'h1,        1);
    add(1, 0,  32'h2,        1, 0,  32'h55,       2'd2, 0, 13, 1, 1, 1, 13, 32'hD,        0);
    add(1, 14, 32'hE1,       1, 14, 32'hE2,       2'd2, 0, 0,  1, 0, 1, 14, 32'hE1,       0);
    add(0, 0,  32'h0,        0, 0,  32'h0,        2'd0, 0, 0,  1, 0, 0, 14, 32'hE1,       0);

    set_idle();
    #2;
    chk("rst_regw", 32'(regw), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tv[k]) begin
      alu_valid = tv[k].av; alu_rd = tv[k].ard; alu_data = tv[k].adata;
      ld_valid = tv[k].lv; ld_rd = tv[k].lrd; ld_data = tv[k].ldata;
      ld_size = tv[k].lsz; ld_unsigned = tv[k].lu;
      q_rs1 = tv[k].q; q_rs2 = tv[k].q;
      #1;
      chk("tv_ready", 32'(ld_ready), 32'(tv[k].e_ready));
      chk("tv_hit1", 32'(hit1), 32'(tv[k].e_hit));
      tick();
      chk("tv_regw", 32'(regw), 32'(tv[k].e_regw));
      chk("tv_waddr", 32'(waddr), 32'(tv[k].e_waddr));
      chk("tv_wdata", wdata, tv[k].e_wdata);
      chk("tv_pending", 32'(pending), 32'(tv[k].e_pend));
    end

    // Reset while two loads are buffered and a write is on the port.
    set_idle();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hA20; ld_size = 2'd2;
    #1; tick();
    alu_rd = 5'd2; alu_data = 32'h2; ld_rd = 5'd21; ld_data = 32'hA21;
    #1; tick();
    chk("pre_rst_regw", 32'(regw), 32'd1);
    chk("pre_rst_pending", 32'(pending), 32'd2);
    reset = 1'b1;
    #1;
    chk("async_rst_regw", 32'(regw), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    mq.delete();
    m_regw = 1'b0; m_waddr = '0; m_wdata = '0;
    #1;
    reset = 1'b0;
    set_idle();
    for (int c = 0; c < 3; c++) begin
      #1; tick();
    end

    for (int c = 0; c < 3000; c++) begin
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      ld_size     = 2'($urandom_range(0, 3));
      ld_unsigned = 1'($urandom_range(0, 1));
      q_rs1       = 5'($urandom_range(0, 7));
      q_rs2       = 5'($urandom_range(0, 7));
      #1; tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
